// File: rtl/apb_mem_arbiter_if.sv
// Bundle of both requester front-ends and the memory-side access port.
// Slave modport is the arbiter's view; master modport is the surrounding fabric.
interface apb_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int BE_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [BE_WIDTH-1:0]   be0;
    logic [BE_WIDTH-1:0]   be1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1,
        input  be0, be1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1,
        output mem_wr, mem_rd, mem_be, mem_address, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1,
        output be0, be1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1,
        input  mem_wr, mem_rd, mem_be, mem_address, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/apb_mem_arbiter.sv
// Two-port round-robin arbiter and single-strobe access sequencer
// in front of a byte-enabled, registered-read word memory.
module apb_mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int BE_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    apb_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    state_t                state_n;
    logic                  load;
    logic                  sel;
    logic                  rr_last;
    logic                  win;
    logic                  l_we;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [BE_WIDTH-1:0]   l_be;
    logic [DATA_WIDTH-1:0] l_wdata;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // RESP re-arbitrates with the just-acked port excluded, so the other
    // port can chain straight into ACCESS.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        sel     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    load    = 1'b1;
                    state_n = ACCESS;
                    if (bus.req0 && bus.req1) begin
                        sel = ~rr_last;
                    end else begin
                        sel = bus.req1;
                    end
                end
            end
            ACCESS: state_n = WAIT;
            WAIT:   state_n = RESP;
            RESP: begin
                sel = ~win;
                if (win ? bus.req0 : bus.req1) begin
                    load    = 1'b1;
                    state_n = ACCESS;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last  <= 1'b1;
            win      <= 1'b0;
            l_we     <= 1'b0;
            l_addr   <= '0;
            l_be     <= '0;
            l_wdata  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (load) begin
                win     <= sel;
                l_we    <= sel ? bus.we1    : bus.we0;
                l_addr  <= sel ? bus.addr1  : bus.addr0;
                l_be    <= sel ? bus.be1    : bus.be0;
                l_wdata <= sel ? bus.wdata1 : bus.wdata0;
            end
            if (state == RESP) begin
                rr_last <= win;
            end
            // Memory read data is registered: it is valid during WAIT.
            if (state == WAIT && !l_we) begin
                if (win) begin
                    rdata1_q <= bus.mem_data_out;
                end else begin
                    rdata0_q <= bus.mem_data_out;
                end
            end
        end
    end

    assign bus.mem_wr      = (state == ACCESS) && l_we;
    assign bus.mem_rd      = (state == ACCESS) && !l_we;
    assign bus.mem_be      = (state == ACCESS) ? l_be : '0;
    assign bus.mem_address = (state == ACCESS) ? l_addr : '0;
    assign bus.mem_data_in = ((state == ACCESS) && l_we) ? l_wdata : '0;
    assign bus.ack0        = (state == RESP) && !win;
    assign bus.ack1        = (state == RESP) && win;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Directed bench for apb_mem_arbiter with a behavioural byte-lane memory
// that returns registered, lane-masked read data.
module tb_apb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    apb_mem_arbiter_if #(
        .ADDR_WIDTH(8),
        .BE_WIDTH(4),
        .DATA_WIDTH(32)
    ) bus ();

    apb_mem_arbiter #(
        .ADDR_WIDTH(8),
        .BE_WIDTH(4),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem [256];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_wr && bus.mem_be[i]) begin
                mem[bus.mem_address][8*i +: 8] <= bus.mem_data_in[8*i +: 8];
            end
            if (bus.mem_rd) begin
                bus.mem_data_out[8*i +: 8] <= bus.mem_be[i] ?
                    mem[bus.mem_address][8*i +: 8] : 8'h00;
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int prot_err = 0;

    always @(negedge clk) begin
        if (bus.mem_wr) wr_cnt <= wr_cnt + 1;
        if (bus.ack0) ack0_cnt <= ack0_cnt + 1;
        if (bus.ack1) ack1_cnt <= ack1_cnt + 1;
        if ((bus.mem_wr && bus.mem_rd) || (bus.ack0 && bus.ack1))
            prot_err <= prot_err + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input bit p, input bit we, input logic [7:0] a,
                          input logic [3:0] be, input logic [31:0] d,
                          output int lat);
        lat = -1;
        if (!p) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a;
            bus.be0 = be; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a;
            bus.be1 = be; bus.wdata1 = d;
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            if ((p ? bus.ack1 : bus.ack0) === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic tie(input logic [7:0] a0, input logic [7:0] a1,
                       output bit first, output int gap);
        first = 1'b0;
        gap = -1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = a0; bus.be0 = 4'hF;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = a1; bus.be1 = 4'hF;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.ack0 || bus.ack1) begin
                first = bus.ack1;
                break;
            end
        end
        if (first) bus.req1 = 1'b0;
        else bus.req0 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if ((first ? bus.ack0 : bus.ack1) === 1'b1) begin
                gap = i;
                break;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
    endtask

    int lat;
    int gap;
    bit first;
    int base;
    int n_ack;
    int ack_port [4];
    int ack_cyc [4];

    initial begin
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.be0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.be1 = 0; bus.wdata1 = 0;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check("rst_strb", {30'd0, bus.mem_wr, bus.mem_rd}, 32'd0);
        check("rst_addr", {20'd0, bus.mem_be, bus.mem_address}, 32'd0);
        check("rst_din", bus.mem_data_in, 32'd0);
        check("rst_rd0", bus.rdata0, 32'd0);
        check("rst_rd1", bus.rdata1, 32'd0);

        do_req(0, 1, 8'h10, 4'hF, 32'hDEADBEEF, lat);
        check("wr_lat", lat, 3);
        check("wr_once", wr_cnt, 1);
        do_req(0, 0, 8'h10, 4'hF, 32'h0, lat);
        check("rd_lat", lat, 3);
        check("rd_data", bus.rdata0, 32'hDEADBEEF);
        check("ack0_n", ack0_cnt, 2);
        check("ack1_n", ack1_cnt, 0);

        do_req(1, 1, 8'h20, 4'hF, 32'h11223344, lat);
        do_req(1, 1, 8'h20, 4'b0101, 32'hAABBCCDD, lat);
        do_req(1, 0, 8'h20, 4'hF, 32'h0, lat);
        check("part_full", bus.rdata1, 32'h11BB33DD);
        do_req(1, 0, 8'h20, 4'b0011, 32'h0, lat);
        check("part_lo", bus.rdata1, 32'h000033DD);
        check("rd0_kept", bus.rdata0, 32'hDEADBEEF);
        do_req(1, 1, 8'h21, 4'hF, 32'h12345678, lat);
        check("wr_keeps_rd", bus.rdata1, 32'h000033DD);

        base = wr_cnt;
        do_req(0, 1, 8'h10, 4'h0, 32'hFFFFFFFF, lat);
        check("be0_strobe", wr_cnt, base + 1);
        do_req(0, 0, 8'h10, 4'hF, 32'h0, lat);
        check("be0_nowrite", bus.rdata0, 32'hDEADBEEF);
        do_req(0, 0, 8'h10, 4'h0, 32'h0, lat);
        check("be0_rd_lat", lat, 3);
        check("be0_rd_zero", bus.rdata0, 32'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_ack = 0;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h30;
        bus.be0 = 4'hF; bus.wdata0 = 32'hA0A0A0A0;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h31;
        bus.be1 = 4'hF; bus.wdata1 = 32'hB1B1B1B1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if ((bus.ack0 || bus.ack1) && n_ack < 4) begin
                ack_port[n_ack] = bus.ack1 ? 1 : 0;
                ack_cyc[n_ack] = i;
                n_ack++;
            end
        end
        bus.req0 = 0;
        bus.req1 = 0;
        repeat (2) tick();
        check("alt_n", n_ack, 4);
        check("alt_p0", ack_port[0], 0);
        check("alt_p1", ack_port[1], 1);
        check("alt_p2", ack_port[2], 0);
        check("alt_p3", ack_port[3], 1);
        check("alt_c0", ack_cyc[0], 3);
        check("alt_c1", ack_cyc[1], 6);
        check("alt_c2", ack_cyc[2], 9);
        check("alt_c3", ack_cyc[3], 12);
        check("alt_m30", mem[8'h30], 32'hA0A0A0A0);
        check("alt_m31", mem[8'h31], 32'hB1B1B1B1);

        tie(8'h30, 8'h31, first, gap);
        check("tie_first", {31'd0, first}, 32'd0);
        check("tie_gap", gap, 3);
        check("tie_rd0", bus.rdata0, 32'hA0A0A0A0);
        check("tie_rd1", bus.rdata1, 32'hB1B1B1B1);
        do_req(1, 0, 8'h20, 4'hF, 32'h0, lat);
        check("solo1_lat", lat, 3);
        check("solo1_data", bus.rdata1, 32'h11BB33DD);

        base = ack0_cnt;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h40;
        bus.be0 = 4'hF; bus.wdata0 = 32'h5555AAAA;
        tick();
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 8'h41; bus.wdata0 = 0;
        check("drop_wr", {31'd0, bus.mem_wr}, 32'd1);
        check("drop_addr", {24'd0, bus.mem_address}, 32'h40);
        check("drop_din", bus.mem_data_in, 32'h5555AAAA);
        repeat (6) tick();
        check("drop_ack", ack0_cnt, base + 1);
        check("drop_mem", mem[8'h40], 32'h5555AAAA);

        base = ack0_cnt;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h40; bus.be0 = 4'hF;
        tick();
        check("rw_rd", {31'd0, bus.mem_rd}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0 = 0;
        check("rw_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        check("rw_rdata", bus.rdata0, 32'd0);
        check("rw_strb", {30'd0, bus.mem_wr, bus.mem_rd}, 32'd0);
        repeat (4) tick();
        check("rw_noack", ack0_cnt, base);
        tie(8'h40, 8'h31, first, gap);
        check("rw_first", {31'd0, first}, 32'd0);
        check("rw_data", bus.rdata0, 32'h5555AAAA);

        check("protocol", prot_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_mem_arbiter.md
Name: apb_mem_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the byte-enabled word memory (MEM_DEPTH byte lanes × MEM_SIZE words).
- Latches one command per grant and issues a single-cycle mem_wr/mem_rd strobe.
- Captures the 1-cycle-latency registered read data and returns a one-cycle ack to the winning requester.
- Sits between two bus-side slave front-ends (for example, the two APB bridge sides) and the memory's memif.

Parameters:
- ADDR_WIDTH, 8, word address width (MEM_SIZE = 2**ADDR_WIDTH).
- BE_WIDTH, 4, byte lanes per word (matches MEM_DEPTH).
- DATA_WIDTH, 32, word width; must equal 8*BE_WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request from port 0 / 1; held high until ack.
- we0 / we1  in  1  1 = write, 0 = read; sampled at grant.
- addr0 / addr1  in  ADDR_WIDTH  word address; sampled at grant.
- be0 / be1  in  BE_WIDTH  byte enables; sampled at grant.
- wdata0 / wdata1  in  DATA_WIDTH  write data; sampled at grant.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_WIDTH  read data, valid with ack; held until that port's next read ack.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_be  out  BE_WIDTH  memory byte enables.
- mem_address  out  ADDR_WIDTH  memory word address.
- mem_data_in  out  DATA_WIDTH  memory write data.
- mem_data_out  in  DATA_WIDTH  memory read data; registered, valid the cycle after mem_rd; lanes with be=0 read as 0.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, rr_last=1 so port 0 wins the first tie.
  - ack0/1=0, rdata0/1=0, all mem_* outputs=0.
  - Reset mid-transaction aborts it: no ack is issued, and any strobe already issued is not undone.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Eligible set = {p : reqp=1}.
  - If non-empty, pick the winner: the single requester, or on a tie the port != rr_last.
  - Latch winner id, we, addr, be, wdata; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address/mem_be = latched values.
  - Write: mem_wr=1, mem_data_in=latched wdata.
  - Read: mem_rd=1.
  - Go to WAIT.
- Outside ACCESS, mem_wr=mem_rd=0 and mem_be/mem_address/mem_data_in=0.
- WAIT:
  - For a read, capture mem_data_out into the winner's rdata register.
  - Go to RESP.
- RESP:
  - ack of the winner = 1 for exactly this cycle; rr_last <= winner.
  - Arbitrate with the acked port excluded.
  - If the other port requests, latch it and go directly to ACCESS; else go to IDLE.
- Latency: ack asserts in the 3rd cycle after the grant cycle (grant→ACCESS→WAIT→RESP).
  - Back-to-back alternating throughput: one access per 3 cycles.
  - Single-port throughput: one access per 4 cycles.
- Write acks leave rdata unchanged.
- be=0:
  - Write: strobe still issued, memory unchanged.
  - Read: returns 0 and still acks.
- Requester protocol:
  - Inputs are sampled only at grant; later changes are ignored.
  - If req drops before ack, the latched command still completes and acks.
  - req still high in IDLE after ack = new request.
- Never more than one of mem_wr/mem_rd high; never both acks high.
- Addresses wrap naturally within ADDR_WIDTH; no range checking.

Test Plan:
- Port0 write addr=0x10, be=4'hF, wdata=0xDEADBEEF, then port0 read 0x10 → mem_wr high exactly 1 cycle; read ack0 3 cycles after grant with rdata0=0xDEADBEEF; ack1 never asserts.
- Partial lanes: write 0x11223344 be=4'hF, write 0xAABBCCDD be=4'b0101 to addr 0x20, read be=4'hF → rdata=0x11BB33DD; read be=4'b0011 → 0x000033DD.
- Both req0 and req1 high continuously, each writing its own address → grants alternate 0,1,0,1 (port 0 first after reset); consecutive acks 3 cycles apart; no port served twice in a row.
- Tie after port1 was last served → port0 wins; single requester port1 with rr_last=1 → port1 still granted, no stall.
- Port0 drops req0 one cycle after grant, and changes addr → original command executes at the original address and ack0 still pulses once.
- Assert rst during WAIT of a read → next cycle all outputs 0, no ack, state IDLE; next request completes normally with port 0 priority.
